spi_main: RTL and testbench

SPI_MAIN -- requirements
Module: spi_main

---
 rtl/spi_main.sv | 116 +++++++++++
 tb/tb_spi_main.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/spi_main.sv
// SPI host for an encrypt/decrypt slave pair: per-slave KEY -> DATA -> READ frame sequencing.
// Latency: done pulses frame length + 1 cycles after start; start is ignored while busy, never queued.
module spi_main (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sel,
  input  logic [0:257] tx,
  input  logic [0:1]   miso,
  output logic [0:127] rx,
  output logic [0:1]   cs_n,
  output logic         sclk,
  output logic         mosi,
  output logic         done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [1:0] P_KEY  = 2'd0;
  localparam logic [1:0] P_DATA = 2'd1;
  localparam logic [1:0] P_READ = 2'd2;

  logic [1:0]   state;
  logic         sel_q;
  logic [1:0]   phase0;
  logic [1:0]   phase1;
  logic [0:257] sh;
  logic [0:127] rd_sh;
  logic [8:0]   cnt;

  logic [1:0]   req_phase;
  logic [1:0]   act_phase;
  logic [0:257] frame;
  logic [8:0]   last_idx;

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    return (p == P_READ) ? P_KEY : 2'(p + 2'd1);
  endfunction

  assign req_phase = sel   ? phase1 : phase0;
  assign act_phase = sel_q ? phase1 : phase0;

  // Frame is left-aligned so bit 0 of the shift register is always the next mosi bit.
  always_comb begin
    frame    = '0;
    last_idx = 9'd127;
    case (req_phase)
      P_KEY: begin
        case (tx[0:1])
          2'b00: begin
            frame    = {tx[0:1], tx[130:257], 128'b0};
            last_idx = 9'd129;
          end
          2'b01: begin
            frame    = {tx[0:1], tx[66:257], 64'b0};
            last_idx = 9'd193;
          end
          default: begin
            frame    = tx;
            last_idx = 9'd257;
          end
        endcase
      end
      P_DATA: frame = {tx[130:257], 130'b0};
      default: frame = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sel_q  <= 1'b0;
      phase0 <= P_KEY;
      phase1 <= P_KEY;
      sh     <= '0;
      rd_sh  <= '0;
      cnt    <= '0;
      rx     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sel_q <= sel;
            sh    <= frame;
            cnt   <= last_idx;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sh    <= {sh[1:257], 1'b0};
          rd_sh <= {rd_sh[1:127], miso[sel_q]};
          cnt   <= cnt - 9'd1;
          if (cnt == 9'd0) begin
            state <= S_FINISH;
            // Capture includes the sample taken on this final edge.
            if (act_phase == P_READ) rx <= {rd_sh[1:127], miso[sel_q]};
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          if (sel_q) phase1 <= next_phase(phase1);
          else       phase0 <= next_phase(phase0);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cs_n = (state != S_SHIFT) ? 2'b11 : (sel_q ? 2'b10 : 2'b01);
  assign mosi = (state == S_SHIFT) & sh[0];
  assign done = (state == S_FINISH);
  assign sclk = clk & (state == S_SHIFT);

endmodule

// File: tb/tb_spi_main.sv
// Directed bench for spi_main: table of transactions walking both slaves through every phase,
// plus hand-written reset and busy-start sequences.
module tb_spi_main;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [257:0] tx = '0;
  logic [0:1]   miso = '0;
  logic [0:127] rx;
  logic [0:1]   cs_n;
  logic         sclk;
  logic         mosi;
  logic         done;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_rx = '0;

  typedef struct {
    logic         sel;
    logic [257:0] tx;
    logic [127:0] miso_w;
    int           len;
    logic [257:0] exp_r;
    logic         rd;
    logic         hold;
    int           gap;
  } vec_t;

  vec_t vecs[8];

  spi_main dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sel   (sel),
    .tx    (tx),
    .miso  (miso),
    .rx    (rx),
    .cs_n  (cs_n),
    .sclk  (sclk),
    .mosi  (mosi),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [257:0] act, input logic [257:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [0:257] cap;
    logic [257:0] exp_l;
    logic [0:1]   cs_exp;
    int idx, lat, cs_bad, tail_bad;
    cap = '0;
    idx = 0;
    lat = 0;
    cs_bad = 0;
    tail_bad = 0;
    cs_exp = v.sel ? 2'b10 : 2'b01;
    repeat (v.gap) @(negedge clk);
    sel = v.sel;
    tx = v.tx;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (!v.hold) start = 1'b0;
      sel = ~v.sel;
      tx = ~v.tx;
      if (done) begin
        lat = c;
        break;
      end
      if (cs_n !== 2'b11) begin
        if (cs_n !== cs_exp) cs_bad++;
        if (idx < 258) cap[idx] = mosi;
        if (idx < 128) miso[v.sel] = v.miso_w[127-idx];
        miso[~v.sel] = 1'($urandom);
        idx++;
      end
    end
    start = 1'b0;
    if (v.rd) exp_rx = v.miso_w;
    exp_l = v.exp_r << (258 - v.len);
    chk("latency", 258'(lat), 258'(v.len + 1));
    chk("bit_count", 258'(idx), 258'(v.len));
    chk("mosi_frame", cap, exp_l);
    chk("cs_n_select", 258'(cs_bad), 258'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || cs_n !== 2'b11 || mosi !== 1'b0) tail_bad++;
    end
    chk("idle_after_done", 258'(tail_bad), 258'(0));
    chk("rx", 258'(rx), 258'(exp_rx));
  endtask

  initial begin
    // sel, tx, miso word, length, expected frame (right-aligned), read, hold start, gap
    vecs[0] = '{1'b0, 258'h000102030405060708090a0b0c0d0e0f, 128'h0,
                130, 258'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, 2};
    vecs[1] = '{1'b0, {2'b11, 128'hffffffffffffffffffffffffffffffff, 128'h00112233445566778899aabbccddeeff},
                128'h0, 128, 258'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, {2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f},
                128'h0, 258, {2'b10, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f},
                1'b0, 1'b0, 2};
    vecs[3] = '{1'b0, {258{1'b1}}, 128'h0123456789abcdeffedcba9876543210,
                128, 258'h0, 1'b1, 1'b0, 70};
    vecs[4] = '{1'b1, {2'b01, 128'h55555555555555555555555555555555, 128'hcafebabe0badf00d13579bdf2468ace0},
                128'h0, 128, 258'hcafebabe0badf00d13579bdf2468ace0, 1'b0, 1'b1, 2};
    vecs[5] = '{1'b0, {2'b01, 64'hffffffffffffffff, 192'h8000000000000001a5a5a5a5a5a5a5a50f0f0f0ff0f0f0f0},
                128'h0, 194, {64'h0, 2'b01, 192'h8000000000000001a5a5a5a5a5a5a5a50f0f0f0ff0f0f0f0},
                1'b0, 1'b0, 2};
    vecs[6] = '{1'b1, {258{1'b1}}, 128'h80000000000000000000000000000001,
                128, 258'h0, 1'b1, 1'b0, 3};
    vecs[7] = '{1'b1, {2'b11, 256'hfedcba98765432100123456789abcdef00112233445566778899aabbccddeeff},
                128'h0, 258, {2'b11, 256'hfedcba98765432100123456789abcdef00112233445566778899aabbccddeeff},
                1'b0, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("reset_cs_n", 258'(cs_n), 258'(2'b11));
    chk("reset_done", 258'(done), 258'(0));
    chk("reset_mosi", 258'(mosi), 258'(0));
    chk("reset_rx", 258'(rx), 258'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset clears rx and returns both slaves to KEY.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset2_rx", 258'(rx), 258'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_rx = '0;

    // Abort a KEY frame mid-way with reset.
    @(negedge clk);
    sel = 1'b0;
    tx = vecs[0].tx;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    chk("mid_sclk_high", 258'(sclk), 258'(1));
    chk("mid_cs_n", 258'(cs_n), 258'(2'b01));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 258'(cs_n), 258'(2'b11));
    chk("abort_done", 258'(done), 258'(0));
    chk("abort_mosi", 258'(mosi), 258'(0));
    begin
      int dcount;
      dcount = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 140; i++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      chk("abort_no_done", 258'(dcount), 258'(0));
    end

    // Next transaction after the abort must be a full KEY frame.
    run_txn(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
